// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multicycle main controller for the simpleMIPS core
//
// Sequences each instruction through FETCH/DECODE/EXE/MEM/WB.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   opcode, funct     instruction fields from the IR
//   zero              ALU zero flag (beq resolution in EXE)
//   mem_ack           data memory completed the current access
//   IRWr, PCWr        IR / PC load enables
//   NPCSel            next-PC source (00 +4, 01 branch, 10 jump, 11 jr)
//   RegWr,WDSel,RDSel register-file write controls
//   ALUSrc,ExtOp,ALUOp ALU operand / operation controls
//   mem_req, mem_we   data-memory request (held until ack) and write
//   illegal           one-cycle pulse on an unsupported encoding
//   state             current state (FETCH=0 .. WB=4)
module mc_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ack,
    output logic       IRWr,
    output logic       PCWr,
    output logic [1:0] NPCSel,
    output logic       RegWr,
    output logic [1:0] WDSel,
    output logic [1:0] RDSel,
    output logic       ALUSrc,
    output logic       ExtOp,
    output logic [2:0] ALUOp,
    output logic       mem_req,
    output logic       mem_we,
    output logic       illegal,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXE    = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_JR   = 6'b001000;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;
    localparam logic [2:0] ALU_LUI = 3'b101;

    state_t     state_q, state_d;
    logic [5:0] op_q, op_d;
    logic [5:0] funct_q, funct_d;

    // DECODE sees the freshly loaded IR directly; later states use the
    // captured copy so the IR may be reused once DECODE has passed.
    logic [5:0] cur_op, cur_fn;
    logic is_r_alu, is_jr, is_ori, is_addiu, is_lui, is_lw, is_sw;
    logic is_beq, is_j, is_jal, is_legal;

    always_comb begin
        cur_op   = (state_q == S_DECODE) ? opcode : op_q;
        cur_fn   = (state_q == S_DECODE) ? funct  : funct_q;
        is_r_alu = (cur_op == OP_RTYPE) &&
                   ((cur_fn == FN_ADDU) || (cur_fn == FN_SUBU) || (cur_fn == FN_AND) ||
                    (cur_fn == FN_OR)   || (cur_fn == FN_SLT));
        is_jr    = (cur_op == OP_RTYPE) && (cur_fn == FN_JR);
        is_ori   = (cur_op == OP_ORI);
        is_addiu = (cur_op == OP_ADDIU);
        is_lui   = (cur_op == OP_LUI);
        is_lw    = (cur_op == OP_LW);
        is_sw    = (cur_op == OP_SW);
        is_beq   = (cur_op == OP_BEQ);
        is_j     = (cur_op == OP_J);
        is_jal   = (cur_op == OP_JAL);
        is_legal = is_r_alu | is_jr | is_ori | is_addiu | is_lui | is_lw |
                   is_sw | is_beq | is_j | is_jal;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            op_q    <= 6'd0;
            funct_q <= 6'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            funct_q <= funct_d;
        end
    end

    logic       irwr_c, pcwr_c, regwr_c, alusrc_c, extop_c;
    logic       mem_req_c, mem_we_c, illegal_c;
    logic [1:0] npcsel_c, wdsel_c, rdsel_c;
    logic [2:0] aluop_c;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        funct_d   = funct_q;
        irwr_c    = 1'b0;
        pcwr_c    = 1'b0;
        npcsel_c  = 2'b00;
        regwr_c   = 1'b0;
        wdsel_c   = 2'b00;
        rdsel_c   = 2'b00;
        alusrc_c  = 1'b0;
        extop_c   = 1'b0;
        aluop_c   = ALU_ADD;
        mem_req_c = 1'b0;
        mem_we_c  = 1'b0;
        illegal_c = 1'b0;

        case (state_q)
            S_FETCH: begin
                irwr_c  = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                op_d    = opcode;
                funct_d = funct;
                if (is_j) begin
                    pcwr_c   = 1'b1;
                    npcsel_c = 2'b10;
                    state_d  = S_FETCH;
                end else if (is_jal) begin
                    regwr_c  = 1'b1;
                    wdsel_c  = 2'b10;
                    rdsel_c  = 2'b10;
                    pcwr_c   = 1'b1;
                    npcsel_c = 2'b10;
                    state_d  = S_FETCH;
                end else if (is_jr) begin
                    pcwr_c   = 1'b1;
                    npcsel_c = 2'b11;
                    state_d  = S_FETCH;
                end else if (!is_legal) begin
                    // skip the bad word: advance PC by 4 and refetch
                    illegal_c = 1'b1;
                    pcwr_c    = 1'b1;
                    state_d   = S_FETCH;
                end else begin
                    state_d = S_EXE;
                end
            end
            S_EXE: begin
                if (is_beq) begin
                    pcwr_c   = 1'b1;
                    npcsel_c = zero ? 2'b01 : 2'b00;
                    state_d  = S_FETCH;
                end else if (is_lw || is_sw) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                mem_req_c = 1'b1;
                mem_we_c  = is_sw;
                if (mem_ack) begin
                    if (is_sw) begin
                        pcwr_c  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                regwr_c = 1'b1;
                pcwr_c  = 1'b1;
                wdsel_c = is_lw ? 2'b01 : 2'b00;
                rdsel_c = is_r_alu ? 2'b00 : 2'b01;
                state_d = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // MEM keeps the EXE ALU controls so the address stays stable
        if (state_q == S_EXE || state_q == S_MEM) begin
            if (is_r_alu) begin
                case (cur_fn)
                    FN_SUBU: aluop_c = ALU_SUB;
                    FN_AND:  aluop_c = ALU_AND;
                    FN_OR:   aluop_c = ALU_OR;
                    FN_SLT:  aluop_c = ALU_SLT;
                    default: aluop_c = ALU_ADD;
                endcase
            end else if (is_ori) begin
                aluop_c  = ALU_OR;
                alusrc_c = 1'b1;
            end else if (is_addiu || is_lw || is_sw) begin
                aluop_c  = ALU_ADD;
                alusrc_c = 1'b1;
                extop_c  = 1'b1;
            end else if (is_lui) begin
                aluop_c  = ALU_LUI;
                alusrc_c = 1'b1;
            end else if (is_beq) begin
                aluop_c  = ALU_SUB;
            end
        end
    end

    // Outputs are forced low while rst is held, so a reset during a
    // MEM stall withdraws mem_req without waiting for a clock edge.
    assign IRWr    = irwr_c    & ~rst;
    assign PCWr    = pcwr_c    & ~rst;
    assign NPCSel  = npcsel_c  & {2{~rst}};
    assign RegWr   = regwr_c   & ~rst;
    assign WDSel   = wdsel_c   & {2{~rst}};
    assign RDSel   = rdsel_c   & {2{~rst}};
    assign ALUSrc  = alusrc_c  & ~rst;
    assign ExtOp   = extop_c   & ~rst;
    assign ALUOp   = aluop_c   & {3{~rst}};
    assign mem_req = mem_req_c & ~rst;
    assign mem_we  = mem_we_c  & ~rst;
    assign illegal = illegal_c & ~rst;
    assign state   = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - scoreboard testbench for mc_ctrl
module tb_mc_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ack = 1'b0;
    logic       IRWr, PCWr, RegWr, ALUSrc, ExtOp, mem_req, mem_we, illegal;
    logic [1:0] NPCSel, WDSel, RDSel;
    logic [2:0] ALUOp, state;

    mc_ctrl dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ack(mem_ack), .IRWr(IRWr), .PCWr(PCWr), .NPCSel(NPCSel),
        .RegWr(RegWr), .WDSel(WDSel), .RDSel(RDSel), .ALUSrc(ALUSrc),
        .ExtOp(ExtOp), .ALUOp(ALUOp), .mem_req(mem_req), .mem_we(mem_we),
        .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    localparam int K_R = 0, K_JR = 1, K_IMM = 2, K_LW = 3, K_SW = 4;
    localparam int K_BEQ = 5, K_J = 6, K_JAL = 7, K_ILL = 8;

    logic [19:0] exp_q[$];
    int checks = 0;
    int failures = 0;

    // {IRWr,PCWr,NPCSel,RegWr,WDSel,RDSel,ALUSrc,ExtOp,ALUOp,mem_req,mem_we,illegal,state}
    function automatic logic [19:0] mk(input int st, input bit irwr, input bit pcwr,
                                       input logic [1:0] npc, input bit regwr,
                                       input logic [1:0] wd, input logic [1:0] rd,
                                       input logic [4:0] alu, input bit req,
                                       input bit we, input bit ill);
        logic [2:0] s3;
        s3 = st[2:0];
        return {irwr, pcwr, npc, regwr, wd, rd, alu, req, we, ill, s3};
    endfunction

    function automatic int kind_of(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h00: begin
                if (fn == 6'h21 || fn == 6'h23 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A)
                    return K_R;
                if (fn == 6'h08) return K_JR;
                return K_ILL;
            end
            6'h0D, 6'h09, 6'h0F: return K_IMM;
            6'h23: return K_LW;
            6'h2B: return K_SW;
            6'h04: return K_BEQ;
            6'h02: return K_J;
            6'h03: return K_JAL;
            default: return K_ILL;
        endcase
    endfunction

    // {ALUSrc, ExtOp, ALUOp} used in EXE/MEM
    function automatic logic [4:0] alu_of(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'h00) begin
            case (fn)
                6'h21: return 5'b00_000;
                6'h23: return 5'b00_001;
                6'h24: return 5'b00_010;
                6'h25: return 5'b00_011;
                default: return 5'b00_100;
            endcase
        end
        case (op)
            6'h0D: return 5'b10_011;
            6'h0F: return 5'b10_101;
            6'h04: return 5'b00_001;
            default: return 5'b11_000;
        endcase
    endfunction

    task automatic cyc(input logic [5:0] o, input logic [5:0] f, input logic z,
                       input logic a, input logic r, input logic [19:0] e);
        @(posedge clk);
        #1;
        opcode  = o;
        funct   = f;
        zero    = z;
        mem_ack = a;
        rst     = r;
        exp_q.push_back(e);
    endtask

    // rst_at >= 0: assert reset in that MEM stall cycle and abandon the instruction
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int w, input int rst_at);
        int k;
        logic [4:0] alu;
        logic [19:0] e;
        k   = kind_of(op, fn);
        alu = alu_of(op, fn);
        cyc(6'($urandom), 6'($urandom), 1'($urandom), 1'($urandom), 1'b0,
            mk(0, 1, 0, 2'b00, 0, 2'b00, 2'b00, 5'd0, 0, 0, 0));
        case (k)
            K_J:   e = mk(1, 0, 1, 2'b10, 0, 2'b00, 2'b00, 5'd0, 0, 0, 0);
            K_JAL: e = mk(1, 0, 1, 2'b10, 1, 2'b10, 2'b10, 5'd0, 0, 0, 0);
            K_JR:  e = mk(1, 0, 1, 2'b11, 0, 2'b00, 2'b00, 5'd0, 0, 0, 0);
            K_ILL: e = mk(1, 0, 1, 2'b00, 0, 2'b00, 2'b00, 5'd0, 0, 0, 1);
            default: e = mk(1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 5'd0, 0, 0, 0);
        endcase
        cyc(op, fn, 1'($urandom), 1'($urandom), 1'b0, e);
        if (k == K_J || k == K_JAL || k == K_JR || k == K_ILL) return;
        if (k == K_BEQ)
            e = mk(2, 0, 1, {1'b0, z}, 0, 2'b00, 2'b00, alu, 0, 0, 0);
        else
            e = mk(2, 0, 0, 2'b00, 0, 2'b00, 2'b00, alu, 0, 0, 0);
        cyc(6'($urandom), 6'($urandom), (k == K_BEQ) ? z : 1'($urandom),
            1'($urandom), 1'b0, e);
        if (k == K_BEQ) return;
        if (k == K_LW || k == K_SW) begin
            for (int i = 0; i <= w; i++) begin
                if (i == rst_at) begin
                    cyc(6'($urandom), 6'($urandom), 1'($urandom), 1'b0, 1'b1, 20'd0);
                    cyc(6'($urandom), 6'($urandom), 1'($urandom), 1'b1, 1'b1, 20'd0);
                    return;
                end
                e = mk(3, 0, (k == K_SW) && (i == w), 2'b00, 0, 2'b00, 2'b00, alu,
                       1, k == K_SW, 0);
                cyc(6'($urandom), 6'($urandom), 1'($urandom), i == w, 1'b0, e);
            end
            if (k == K_SW) return;
        end
        e = mk(4, 0, 1, 2'b00, 1, (k == K_LW) ? 2'b01 : 2'b00,
               (k == K_R) ? 2'b00 : 2'b01, 5'd0, 0, 0, 0);
        cyc(6'($urandom), 6'($urandom), 1'($urandom), 1'($urandom), 1'b0, e);
    endtask

    // monitor: one expected output vector per cycle, compared mid-cycle
    always @(negedge clk) begin
        logic [19:0] act, e;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = {IRWr, PCWr, NPCSel, RegWr, WDSel, RDSel, ALUSrc, ExtOp, ALUOp,
                   mem_req, mem_we, illegal, state};
            checks++;
            if (act !== e) begin
                failures++;
                $display("FAIL outputs t=%0t got=%05h exp=%05h (state got %0d exp %0d)",
                         $time, act, e, act[2:0], e[2:0]);
            end
        end
    end

    initial begin
        logic [5:0] o, f;
        int sel;
        // reset held: all outputs low
        for (int i = 0; i < 3; i++)
            cyc(6'($urandom), 6'($urandom), 1'($urandom), 1'($urandom), 1'b1, 20'd0);
        // directed cases
        run_instr(6'h00, 6'h21, 1'b0, 0, -1);   // addu
        run_instr(6'h23, 6'h00, 1'b0, 3, -1);   // lw, 3 wait cycles
        run_instr(6'h04, 6'h00, 1'b1, 0, -1);   // beq taken
        run_instr(6'h04, 6'h00, 1'b0, 0, -1);   // beq not taken
        run_instr(6'h03, 6'h00, 1'b0, 0, -1);   // jal
        run_instr(6'h3F, 6'h00, 1'b0, 0, -1);   // illegal opcode
        run_instr(6'h00, 6'h3F, 1'b0, 0, -1);   // illegal funct
        run_instr(6'h2B, 6'h00, 1'b0, 0, -1);   // sw zero wait
        run_instr(6'h2B, 6'h00, 1'b0, 5, 2);    // sw, reset mid-stall
        run_instr(6'h00, 6'h08, 1'b0, 0, -1);   // jr after reset
        // randomized mix
        for (int n = 0; n < 120; n++) begin
            sel = $urandom_range(0, 15);
            case (sel)
                0: begin o = 6'h00; f = 6'h21; end
                1: begin o = 6'h00; f = 6'h23; end
                2: begin o = 6'h00; f = 6'h24; end
                3: begin o = 6'h00; f = 6'h25; end
                4: begin o = 6'h00; f = 6'h2A; end
                5: begin o = 6'h00; f = 6'h08; end
                6: begin o = 6'h0D; f = 6'($urandom); end
                7: begin o = 6'h09; f = 6'($urandom); end
                8: begin o = 6'h0F; f = 6'($urandom); end
                9: begin o = 6'h23; f = 6'($urandom); end
                10: begin o = 6'h2B; f = 6'($urandom); end
                11: begin o = 6'h04; f = 6'($urandom); end
                12: begin o = 6'h02; f = 6'($urandom); end
                13: begin o = 6'h03; f = 6'($urandom); end
                default: begin o = 6'($urandom); f = 6'($urandom); end
            endcase
            run_instr(o, f, 1'($urandom), $urandom_range(0, 4), -1);
        end
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
